// File: rtl/varredor_teclado_pkg.sv
// rtl/varredor_teclado_pkg.sv - shared encodings and width helpers for the keypad scanner
package varredor_teclado_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    typedef enum logic [1:0] {
        SCAN     = ST_SCAN,
        DEBOUNCE = ST_DEBOUNCE,
        HOLD     = ST_HOLD
    } state_t;

    // Smallest r with 2**r >= value; evaluated at elaboration only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of {row, column index}; downstream consumers size their buses with this.
    function automatic int key_code_width(input int n, input int c);
        return n + clog2(c);
    endfunction

endpackage

// File: rtl/varredor_teclado_sincronizador_2ff.sv
// rtl/varredor_teclado_sincronizador_2ff.sv - two-flop synchronizer for asynchronous column lines
module sincronizador_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back stages give the first flop a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/varredor_teclado.sv
// rtl/varredor_teclado.sv - matrix keypad row scanner with debounce and valid/ready key output
module varredor_teclado
    import varredor_teclado_pkg::*;
#(
    parameter int N        = 2,
    parameter int C        = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [C-1:0]                   col,
    output logic [N-1:0]                   a,
    output logic [key_code_width(N, C)-1:0] key_code,
    output logic                           key_valid,
    input  logic                           key_ready,
    output logic                           overrun,
    output logic                           busy
);

    localparam int CW = clog2(C);
    localparam int PW = clog2(SCAN_DIV);
    localparam int DW = clog2(DEB_CNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CNT - 1);

    logic [C-1:0]  col_s;
    logic [PW-1:0] presc;
    logic          tick;
    state_t        state;
    logic [N-1:0]  row;
    logic [CW-1:0] col_idx;
    logic [CW-1:0] low_idx;
    logic [DW-1:0] cnt;
    logic          hit;
    logic          confirm;

    sincronizador_2ff #(.W(C)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col),
        .q     (col_s)
    );

    assign tick = (presc == PRESC_LAST);
    assign hit  = col_s[col_idx];

    // A press is confirmed on the tick whose agreeing sample would bring the count to DEB_CNT.
    assign confirm = (state == DEBOUNCE) && tick && hit && (cnt == DEB_LAST);

    // Row dwell prescaler: one tick every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Lowest-numbered active column wins when several are pressed in the same row.
    always_comb begin
        low_idx = '0;
        for (int i = C - 1; i >= 0; i--) begin
            if (col_s[i]) begin
                low_idx = CW'(i);
            end
        end
    end

    // Scan/debounce/hold state machine; the row address only advances while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SCAN;
            a       <= '0;
            row     <= '0;
            col_idx <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (tick) begin
            case (state)
                SCAN: begin
                    if (|col_s) begin
                        row     <= a;
                        col_idx <= low_idx;
                        cnt     <= DW'(1);
                        state   <= DEBOUNCE;
                        busy    <= 1'b1;
                    end else begin
                        a <= a + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (hit) begin
                        if (cnt == DEB_LAST) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state <= SCAN;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        a     <= a + 1'b1;
                    end
                end
                HOLD: begin
                    if (!hit) begin
                        if (cnt == DEB_LAST) begin
                            state <= SCAN;
                            busy  <= 1'b0;
                            cnt   <= '0;
                            a     <= a + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    state <= SCAN;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Single-entry output register; a confirmed key arriving while the slot is full is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (confirm) begin
                if (!key_valid || key_ready) begin
                    key_code  <= {row, col_idx};
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/varredor_teclado.md
# varredor_teclado

Matrix-keypad scan controller. It generates the row address that drives the team's parametric N→2^N one-hot decoder (`decodificador_N_M_*`), and the decoder output selects one keypad row at a time. The block samples the column lines, debounces presses and releases, and delivers one key code per press through a valid/ready output register. It sits directly upstream of the decoder and is the sole source of its `a` input.

## Interface
- `N`, 2: row-address width; rows = 2^N.
- `C`, 4: column count, ≥2; CW = clog2(C).
- `SCAN_DIV`, 1000: clock cycles per scan tick (row dwell), ≥4.
- `DEB_CNT`, 4: consecutive agreeing samples needed to confirm a press or a release, ≥2.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `col`  in  C  column lines, active-high = pressed; asynchronous to `clk`.
- `a`  out  N  row address to decoder.
- `key_code`  out  N+CW  {row, column index}.
- `key_valid`  out  1  key_code holds an unconsumed key.
- `key_ready`  in  1  consumer accepts when `key_valid` and `key_ready` are both high at a rising edge.
- `overrun`  out  1  one-cycle pulse when a confirmed key is dropped.
- `busy`  out  1  high in any state other than SCAN.

## Operation
- `col` passes through a 2-FF synchronizer. All sampling uses the synchronized value `col_s`.
- The prescaler counts 0..SCAN_DIV-1 and wraps. A tick is the cycle where prescaler = SCAN_DIV-1. A sample is `col_s` taken on a tick.
- Reset values: `a`=0, prescaler=0, state SCAN, `key_code`=0, `key_valid`=0, `overrun`=0, `busy`=0, debounce counter=0.
- SCAN:
  - On a tick with `col_s`=0, `a` increments (2^N-1 wraps to 0).
  - On a tick with any `col_s` bit set, latch row=`a` and col_idx = lowest set bit index. Set counter to 1. Go to DEBOUNCE. `a` is frozen.
- DEBOUNCE:
  - On each tick, if `col_s[col_idx]` is high, counter++. When the counter reaches DEB_CNT, the key is confirmed. Go to HOLD and reset the counter to 0.
  - If `col_s[col_idx]` is low on a tick, return to SCAN and increment `a` on that same tick.
- HOLD:
  - `a` stays frozen.
  - On each tick, a low `col_s[col_idx]` increments the counter; a high one clears it.
  - When the counter reaches DEB_CNT, return to SCAN and increment `a` on that tick.
- Other keys are ignored while in DEBOUNCE or HOLD.
- Output register, evaluated at the confirmation edge:
  - If `key_valid`=0, or `key_valid`=1 with `key_ready`=1: load `key_code`={row, col_idx} and set `key_valid`=1.
  - If `key_valid`=1 with `key_ready`=0: drop the new key, pulse `overrun` for one cycle, and leave `key_code` unchanged.
  - With no confirmation, `key_valid` && `key_ready` clears `key_valid`. `key_code` keeps its last value.

## Timing
- Row dwell is exactly SCAN_DIV cycles. `a` changes only on the clock edge that ends a tick.
- Synchronizer latency is 2 cycles. Decoder settling plus sync latency must finish before the tick, hence SCAN_DIV ≥ 4.
- Press latency: `key_valid` rises on the edge at the end of tick number DEB_CNT, counting the detection tick as tick 1. That is (DEB_CNT-1)·SCAN_DIV cycles after the detection edge.
- Release: SCAN resumes DEB_CNT ticks after the first low sample, provided no high sample interrupts the run.
- Asserting `rst_n` low at any time, including mid-debounce or mid-handshake, immediately forces all reset values. Any pending key is lost.
- `overrun` is never high for two consecutive cycles from a single event.

## Structure
- The shared package holds:
  - state encodings SCAN/DEBOUNCE/HOLD (2-bit localparams);
  - a clog2 function;
  - the key-code width expression N+CW, also used by downstream consumers.
- Sub-module: `sincronizador_2ff`, parameterized by width and instantiated with width C.
- The prescaler, row counter, FSM and output register stay in the top module.
- The decoder is instantiated beside this block at the integration level, not inside it.

## Test plan
Bench parameters unless noted: N=2, C=4, SCAN_DIV=4, DEB_CNT=3.
- **Reset and idle scan:** `rst_n` low then high, `col`=0 → `a` steps 0,1,2,3,0 every 4 cycles; `key_valid`=0; `busy`=0.
- **Clean press and release:** hold `col[2]`=1 only while `a`=1 → `key_code`=4'b0110 and `key_valid`=1 eight cycles after the detection edge; `a` stays 1 throughout. After release, `a`=2 three ticks later.
- **Bounce rejection:** `col[0]` high for exactly one sample in row 3 → `key_valid` stays 0; SCAN resumes and `a` becomes 0 on the next tick.
- **Priority:** `col[1]` and `col[3]` high in row 3 → `key_code`=4'b1101.
- **Backpressure:** `key_ready`=0 with two full press/release cycles (row 0 col 0, then row 2 col 1) → `key_code` stays 4'b0000 and `overrun` pulses once. Then `key_ready`=1 → `key_valid` clears.
- **Reset mid-operation:** assert `rst_n` low during DEBOUNCE and again with `key_valid`=1 → all outputs at reset values asynchronously; scan restarts at `a`=0.
